// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet-state tick scheduler: FSM encoding and
// default channel geometry.
package tamagotchi_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_ID_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CLR,
        S_WAIT,
        S_TICK
    } sched_state_t;

endpackage

// File: rtl/tick_scheduler_rr_picker.sv
// Combinational round-robin selector: lowest requesting index at or above
// the pointer, wrapping to the lowest requester overall.
module rr_picker
    import tamagotchi_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int ID_W = DEF_ID_W
) (
    input  logic [NCH-1:0]  req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            any
);

    logic            hi_found;
    logic [ID_W-1:0] hi_id;
    logic            lo_found;
    logic [ID_W-1:0] lo_id;

    // Scanning downward lets the last hit be the lowest index in each half.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (ID_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
            end
        end
        grant = hi_found ? hi_id : lo_id;
        any   = lo_found;
    end

endmodule

// File: rtl/tick_scheduler.sv
// Shares one one-shot seconds timer among NCH periodic channels and offers
// expired channels to the game FSM through a round-robin valid/ready port.
module tick_scheduler
    import tamagotchi_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH*CNT_W-1:0] period,
    output logic                 tmr_init,
    input  logic                 tmr_done,
    output logic                 tick,
    output logic                 evt_valid,
    output logic [ID_W-1:0]      evt_id,
    input  logic                 evt_ready,
    output logic [NCH-1:0]       overrun,
    input  logic                 ovr_clr
);

    sched_state_t state;
    sched_state_t state_nxt;

    logic [CNT_W-1:0] prd     [NCH];
    logic [CNT_W-1:0] cnt     [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];

    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  due;
    logic [NCH-1:0]  expire;
    logic [NCH-1:0]  accept_vec;
    logic [NCH-1:0]  ovr_set;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] lock_id;
    logic            lock_vld;
    logic            lock_hit;
    logic            any_req;
    logic            accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_init  = 1'b0;
        tick      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                tmr_init  = 1'b1;
                state_nxt = S_CLR;
            end
            // The timer may still show a stale expiry until it samples init.
            S_CLR: begin
                if (!tmr_done) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tmr_done) begin
                    state_nxt = S_TICK;
                end
            end
            S_TICK: begin
                tick      = 1'b1;
                state_nxt = run ? S_ARM : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            prd[i] = period[i*CNT_W +: CNT_W];
        end
    end

    // A fresh channel counts the current tick as its first second, so a
    // period of 1 fires every tick and period N fires on every Nth tick.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            due[i]     = 1'b0;
            cnt_nxt[i] = cnt[i];
            if (!ch_en[i] || prd[i] == '0) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == '0) begin
                cnt_nxt[i] = prd[i] - CNT_W'(1);
                due[i]     = (prd[i] == CNT_W'(1));
            end else if (cnt[i] == CNT_W'(1)) begin
                cnt_nxt[i] = prd[i];
                due[i]     = 1'b1;
            end else begin
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
        end
    end

    assign expire = due & {NCH{tick}};

    rr_picker #(
        .NCH  (NCH),
        .ID_W (ID_W)
    ) u_picker (
        .req   (pending),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_req)
    );

    // A stalled offer keeps its index unless that channel was withdrawn.
    always_comb begin
        lock_hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (pending[i] && lock_id == ID_W'(i)) begin
                lock_hit = 1'b1;
            end
        end
    end

    assign evt_valid = any_req;
    assign evt_id    = (lock_vld && lock_hit) ? lock_id : grant;
    assign accept    = evt_valid & evt_ready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            accept_vec[i] = accept && (evt_id == ID_W'(i));
        end
    end

    assign ovr_set = expire & pending & ~accept_vec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= '0;
            overrun  <= '0;
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!ch_en[i]) begin
                    pending[i] <= 1'b0;
                    cnt[i]     <= '0;
                end else begin
                    pending[i] <= (pending[i] & ~accept_vec[i]) | expire[i];
                    if (tick) begin
                        cnt[i] <= cnt_nxt[i];
                    end
                end
            end
            overrun <= ovr_set | (overrun & ~{NCH{ovr_clr}});
            if (accept) begin
                rr_ptr <= (evt_id == ID_W'(NCH - 1)) ? '0 : evt_id + ID_W'(1);
            end
            lock_vld <= evt_valid & ~evt_ready;
            lock_id  <= evt_id;
        end
    end

endmodule
